// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register: IDLE-cycle operations, burst FSM states, burst direction.
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control and data bundle of the universal shift register; master drives the controls, slave is the register.
// The rot input exists only when SHREG_ROTATE_EN is defined.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] count;
`ifdef SHREG_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

`ifdef SHREG_ROTATE_EN
  modport master (output clr, mode, data, sin_l, sin_r, start, dir, count, rot,
                  input  q, qbar, sout_l, sout_r, busy, done);
  modport slave  (input  clr, mode, data, sin_l, sin_r, start, dir, count, rot,
                  output q, qbar, sout_l, sout_r, busy, done);
`else
  modport master (output clr, mode, data, sin_l, sin_r, start, dir, count,
                  input  q, qbar, sout_l, sout_r, busy, done);
  modport slave  (input  clr, mode, data, sin_l, sin_r, start, dir, count,
                  output q, qbar, sout_l, sout_r, busy, done);
`endif

endinterface

// File: rtl/shreg_burst_ctl.sv
// Burst sequencer: IDLE/SHIFT/DONE FSM with a down-counter; one shift enable per SHIFT cycle.
// Outputs are state decodes (no added latency); clr aborts to IDLE without a done pulse.
module shreg_burst_ctl
  import shreg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  output logic             shift_en,
  output logic             shift_dir,
  output logic             idle,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    shift_en = 1'b0;
    idle     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle = 1'b1;
        if (start) begin
          if (count != '0) begin
            rem_d   = count;
            dir_d   = dir;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        rem_d    = rem_q - CNT_W'(1);
        // Leave on the cycle doing the last shift, so count=N yields N busy cycles.
        if (rem_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d  = ST_IDLE;
      rem_d    = '0;
      shift_en = 1'b0;
    end
  end

  assign shift_dir = dir_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/shift/load per IDLE cycle plus counted bursts; q updates one edge after inputs.
// No backpressure: controls other than clr are ignored outside IDLE. SHREG_ROTATE_EN adds the rot input.
module shift_reg_univ
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_reg_univ_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shl, shr;
  logic             rot, fill_l, fill_r;
  logic             shift_en, shift_dir, idle;

`ifdef SHREG_ROTATE_EN
  assign rot = bus.rot;
`else
  assign rot = 1'b0;
`endif

  // Rotation recirculates the bit falling off the opposite end.
  assign fill_l = rot ? q_q[WIDTH-1] : bus.sin_l;
  assign fill_r = rot ? q_q[0]       : bus.sin_r;
  assign shl    = {q_q[WIDTH-2:0], fill_l};
  assign shr    = {fill_r, q_q[WIDTH-1:1]};

  shreg_burst_ctl #(.CNT_W(CNT_W)) u_ctl (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bus.clr),
    .start    (bus.start),
    .dir      (bus.dir),
    .count    (bus.count),
    .shift_en (shift_en),
    .shift_dir(shift_dir),
    .idle     (idle),
    .busy     (bus.busy),
    .done     (bus.done)
  );

  always_comb begin
    q_d = q_q;
    if (bus.clr) begin
      q_d = '0;
    end else if (shift_en) begin
      q_d = (shift_dir == DIR_RIGHT) ? shr : shl;
    end else if (idle && !bus.start) begin
      case (mode_e'(bus.mode))
        MODE_SHL:  q_d = shl;
        MODE_SHR:  q_d = shr;
        MODE_LOAD: q_d = bus.data;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign bus.q      = q_q;
  assign bus.qbar   = ~q_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboarded bench for shift_reg_univ: a reference model pushes expected state per driven cycle, popped after the edge.
module tb_shift_reg_univ;
  import shreg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shift_reg_univ_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_reg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_busy  = 0;
  int   n_done  = 0;

  // Reference model state: 0 idle, 1 shifting, 2 done.
  logic [WIDTH-1:0] m_q;
  int               m_state;
  int               m_rem;
  logic             m_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q     = '0;
    m_state = 0;
    m_rem   = 0;
    m_dir   = 1'b0;
  endtask

  task automatic model_step();
    logic rot_v, fl, fr;
    rot_v = 1'b0;
`ifdef SHREG_ROTATE_EN
    rot_v = bus.rot;
`endif
    fl = rot_v ? m_q[WIDTH-1] : bus.sin_l;
    fr = rot_v ? m_q[0]       : bus.sin_r;
    if (bus.clr) begin
      model_reset();
    end else if (m_state == 0) begin
      if (bus.start) begin
        if (bus.count == 0) begin
          m_state = 2;
        end else begin
          m_rem   = int'(bus.count);
          m_dir   = bus.dir;
          m_state = 1;
        end
      end else begin
        case (bus.mode)
          2'b01:   m_q = {m_q[WIDTH-2:0], fl};
          2'b10:   m_q = {fr, m_q[WIDTH-1:1]};
          2'b11:   m_q = bus.data;
          default: m_q = m_q;
        endcase
      end
    end else if (m_state == 1) begin
      m_q   = m_dir ? {fr, m_q[WIDTH-1:1]} : {m_q[WIDTH-2:0], fl};
      m_rem = m_rem - 1;
      if (m_rem == 0) m_state = 2;
    end else begin
      m_state = 0;
    end
  endtask

  // One clock: predict, push, let the edge happen, then pop and compare.
  task automatic tick();
    exp_t             e;
    logic [WIDTH-1:0] eqb;
    model_step();
    e.q    = m_q;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    eqb = ~e.q;
    check("q",      32'(bus.q),      32'(e.q));
    check("qbar",   32'(bus.qbar),   32'(eqb));
    check("sout_l", 32'(bus.sout_l), 32'(e.q[WIDTH-1]));
    check("sout_r", 32'(bus.sout_r), 32'(e.q[0]));
    check("busy",   32'(bus.busy),   32'(e.busy));
    check("done",   32'(bus.done),   32'(e.done));
    if (bus.busy) n_busy++;
    if (bus.done) n_done++;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    bus.start = 1'b0;
    bus.mode  = MODE_LOAD;
    bus.data  = v;
    tick();
    bus.mode  = MODE_HOLD;
  endtask

  task automatic fire(input logic d, input int cnt);
    bus.start = 1'b1;
    bus.dir   = d;
    bus.count = CNT_W'(cnt);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clr   = 1'b0;
    bus.mode  = MODE_HOLD;
    bus.data  = '0;
    bus.sin_l = 1'b0;
    bus.sin_r = 1'b0;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.count = '0;
`ifdef SHREG_ROTATE_EN
    bus.rot   = 1'b0;
`endif
    model_reset();

    #12;
    check("rst_q",    32'(bus.q),    32'h00);
    check("rst_qbar", 32'(bus.qbar), 32'hFF);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset_n = 1'b1;

    // Load then hold.
    load(8'hA5);
    check("load_q", 32'(bus.q), 32'hA5);
    repeat (3) begin
      tick();
      check("hold_q",    32'(bus.q),    32'hA5);
      check("hold_qbar", 32'(bus.qbar), 32'h5A);
    end

    // Left burst of 3 from 8'h81; mode during the burst must be ignored.
    load(8'h81);
    bus.sin_l = 1'b0;
    n_busy = 0; n_done = 0;
    fire(1'b0, 3);
    bus.mode = MODE_LOAD; bus.data = 8'hFF; bus.count = CNT_W'(7);
    tick(); tick(); tick();
    check("burst_q", 32'(bus.q), 32'h08);
    check("burst_done_4th", 32'(bus.done), 32'h1);
    bus.mode = MODE_HOLD;
    tick();
    check("burst_busy_cycles", 32'(n_busy), 32'd3);
    check("burst_done_pulses", 32'(n_done), 32'd1);

    // Zero-count burst.
    n_busy = 0; n_done = 0;
    fire(1'b1, 0);
    check("zero_done", 32'(bus.done), 32'h1);
    check("zero_q",    32'(bus.q),    32'h08);
    // Start held through DONE is accepted only in the following IDLE cycle.
    bus.start = 1'b1; bus.dir = 1'b1; bus.count = CNT_W'(1); bus.sin_r = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    tick(); tick();
    check("zero_busy_cycles", 32'(n_busy), 32'd1);
    check("b2b_q", 32'(bus.q), 32'h84);

    // Clear in the second SHIFT cycle of a 5-shift burst.
    load(8'h5A);
    n_done = 0;
    fire(1'b1, 5);
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_q",    32'(bus.q),    32'h00);
    check("clr_busy", 32'(bus.busy), 32'h0);
    repeat (6) tick();
    check("clr_no_done", 32'(n_done), 32'd0);

    // Maximum count: 15 shifts of ones into zero.
    n_busy = 0; n_done = 0;
    bus.sin_l = 1'b1;
    fire(1'b0, 15);
    repeat (16) tick();
    check("max_busy_cycles", 32'(n_busy), 32'd15);
    check("max_done_pulses", 32'(n_done), 32'd1);
    check("max_q", 32'(bus.q), 32'hFF);

    // Async reset mid-burst, away from any edge.
    load(8'h3C);
    fire(1'b1, 10);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_q",    32'(bus.q),    32'h00);
    check("arst_qbar", 32'(bus.qbar), 32'hFF);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    model_reset();
    #2;
    reset_n = 1'b1;
    load(8'h96);
    check("post_rst_load", 32'(bus.q), 32'h96);

`ifdef SHREG_ROTATE_EN
    load(8'h81);
    bus.rot  = 1'b1;
    bus.mode = MODE_SHR;
    tick();
    check("rot_shr", 32'(bus.q), 32'hC0);
    bus.rot  = 1'b0;
    bus.mode = MODE_HOLD;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      bus.clr   = ($urandom_range(0, 19) == 0);
      bus.mode  = 2'($urandom_range(0, 3));
      bus.data  = WIDTH'($urandom);
      bus.sin_l = 1'($urandom);
      bus.sin_r = 1'($urandom);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.dir   = 1'($urandom);
      bus.count = CNT_W'($urandom_range(0, 6));
`ifdef SHREG_ROTATE_EN
      bus.rot   = 1'($urandom);
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
